// File: rtl/core_pipe_exec_lsu_pkg.sv
// Shared LSU definitions: access sizes, trap cause codes and FSM state encoding.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package core_pipe_exec_lsu_pkg;

  localparam logic [1:0] LSU_SIZE_B = 2'd0;
  localparam logic [1:0] LSU_SIZE_H = 2'd1;
  localparam logic [1:0] LSU_SIZE_W = 2'd2;
  localparam logic [1:0] LSU_SIZE_D = 2'd3;

  localparam logic [2:0] CAUSE_NONE        = 3'd0;
  localparam logic [2:0] CAUSE_LD_MISALIGN = 3'd1;
  localparam logic [2:0] CAUSE_LD_FAULT    = 3'd2;
  localparam logic [2:0] CAUSE_ST_MISALIGN = 3'd3;
  localparam logic [2:0] CAUSE_ST_FAULT    = 3'd4;

  typedef enum logic [2:0] {
    LSU_IDLE  = 3'd0,
    LSU_REQ   = 3'd1,
    LSU_DRAIN = 3'd2,
    LSU_DONE  = 3'd3,
    LSU_TRAP  = 3'd4
  } lsu_state_e;

endpackage

// File: rtl/core_pipe_exec_lsu_fmt.sv
// Byte-lane formatter: store strobes/lane shift and load lane extract with sign/zero extension.
// Latency: purely combinational.
// Backpressure: none; the caller decides when outputs are used.
module core_pipe_exec_lsu_fmt import core_pipe_exec_lsu_pkg::*; #(
  parameter int XLEN       = 64,
  parameter int MEM_DATA_W = 64,
  parameter int STRB_W     = MEM_DATA_W / 8,
  parameter int OFF_W      = $clog2(MEM_DATA_W / 8)
) (
  input  logic [1:0]            size_i,
  input  logic                  signed_i,
  input  logic [OFF_W-1:0]      off_i,
  input  logic [XLEN-1:0]       wdata_i,
  input  logic [MEM_DATA_W-1:0] rdata_i,
  output logic [STRB_W-1:0]     strb_o,
  output logic [MEM_DATA_W-1:0] wdata_o,
  output logic [XLEN-1:0]       rdata_o
);

  logic [MEM_DATA_W-1:0] wext;
  logic [MEM_DATA_W-1:0] rsh;
  logic                  sbit;
  int                    nbits;

  // Strobe covers 2^size bytes starting at the lane offset.
  always_comb begin
    strb_o = '0;
    for (int i = 0; i < STRB_W; i++) begin
      if (i >= int'(off_i) && i < int'(off_i) + (1 << size_i)) strb_o[i] = 1'b1;
    end
  end

  // Store data is zero-extended to the bus and moved up to its byte lane.
  always_comb begin
    wext = '0;
    wext[XLEN-1:0] = wdata_i;
    wdata_o = wext << {off_i, 3'b000};
  end

  // Load data is moved down from its lane, then bits above the access width are replaced by the extension bit.
  always_comb begin
    rsh = rdata_i >> {off_i, 3'b000};
    case (size_i)
      LSU_SIZE_B: begin nbits = 8;    sbit = signed_i & rsh[7];      end
      LSU_SIZE_H: begin nbits = 16;   sbit = signed_i & rsh[15];     end
      LSU_SIZE_W: begin nbits = 32;   sbit = signed_i & rsh[31];     end
      default:    begin nbits = XLEN; sbit = signed_i & rsh[XLEN-1]; end
    endcase
    rdata_o = '0;
    for (int i = 0; i < XLEN; i++) begin
      rdata_o[i] = (i < nbits) ? rsh[i] : sbit;
    end
  end

endmodule

// File: rtl/core_pipe_exec_lsu.sv
// Execute-stage LSU: one dmem request/grant transaction per op, with alignment, strobes, load extension, traps and flush.
// Latency: request the cycle after start; ready/rd_wen one cycle after gnt (gnt cycle itself with CORE_LSU_FAST_RESP_EN); misalign trap the cycle after start.
// Backpressure: request and its payload held stable until dmem_gnt; lsu_ready low while a transfer is outstanding or draining.
module core_pipe_exec_lsu import core_pipe_exec_lsu_pkg::*; #(
  parameter int XLEN       = 64,
  parameter int MEM_ADDR_W = 64,
  parameter int MEM_DATA_W = 64
) (
  input  logic                    g_clk,
  input  logic                    g_resetn,
  input  logic                    lsu_valid,
  input  logic                    lsu_new_instr,
  input  logic                    lsu_flush,
  input  logic                    lsu_load,
  input  logic                    lsu_store,
  input  logic [1:0]              lsu_size,
  input  logic                    lsu_signed,
  input  logic [XLEN-1:0]         lsu_addr,
  input  logic [XLEN-1:0]         lsu_wdata,
  output logic                    lsu_ready,
  output logic                    lsu_rd_wen,
  output logic [XLEN-1:0]         lsu_rdata,
  output logic                    lsu_trap,
  output logic [2:0]              lsu_trap_cause,
  output logic                    dmem_req,
  output logic [MEM_ADDR_W-1:0]   dmem_addr,
  output logic                    dmem_wen,
  output logic [MEM_DATA_W/8-1:0] dmem_strb,
  output logic [MEM_DATA_W-1:0]   dmem_wdata,
  input  logic                    dmem_gnt,
  input  logic                    dmem_err,
  input  logic [MEM_DATA_W-1:0]   dmem_rdata
);

  localparam int STRB_W = MEM_DATA_W / 8;
  localparam int OFF_W  = $clog2(STRB_W);
  localparam int AW     = (MEM_ADDR_W < XLEN) ? MEM_ADDR_W : XLEN;

  lsu_state_e            state_q;
  logic                  load_q, signed_q, wen_q, rd_wen_q;
  logic [1:0]            size_q;
  logic [OFF_W-1:0]      off_q;
  logic [2:0]            cause_q;
  logic [MEM_ADDR_W-1:0] addr_q, addr_d;
  logic [STRB_W-1:0]     strb_q;
  logic [MEM_DATA_W-1:0] wdata_q;
  logic [XLEN-1:0]       rdata_q;

  logic                  start, misaligned, fast_hit;
  logic [OFF_W-1:0]      off;
  logic [1:0]            fmt_size;
  logic [OFF_W-1:0]      fmt_off;
  logic [STRB_W-1:0]     fmt_strb;
  logic [MEM_DATA_W-1:0] fmt_wdata;
  logic [XLEN-1:0]       fmt_rdata;

  assign start = lsu_valid && (lsu_load || lsu_store) && !lsu_flush;
  assign off   = lsu_addr[OFF_W-1:0];

  // Natural alignment check; doubleword accesses never fit a 32-bit GPR.
  always_comb begin
    case (lsu_size)
      LSU_SIZE_B: misaligned = 1'b0;
      LSU_SIZE_H: misaligned = lsu_addr[0];
      LSU_SIZE_W: misaligned = |lsu_addr[1:0];
      default:    misaligned = (|lsu_addr[2:0]) || (XLEN == 32);
    endcase
  end

  // Bus address is the lane-aligned op address, resized to the bus width.
  always_comb begin
    addr_d = '0;
    addr_d[AW-1:0] = lsu_addr[AW-1:0];
    addr_d[OFF_W-1:0] = '0;
  end

  // The formatter sees the live op while idle (store path) and the latched op afterwards (load path).
  assign fmt_size = (state_q == LSU_IDLE) ? lsu_size : size_q;
  assign fmt_off  = (state_q == LSU_IDLE) ? off : off_q;

  core_pipe_exec_lsu_fmt #(
    .XLEN       (XLEN),
    .MEM_DATA_W (MEM_DATA_W)
  ) u_fmt (
    .size_i   (fmt_size),
    .signed_i (signed_q),
    .off_i    (fmt_off),
    .wdata_i  (lsu_wdata),
    .rdata_i  (dmem_rdata),
    .strb_o   (fmt_strb),
    .wdata_o  (fmt_wdata),
    .rdata_o  (fmt_rdata)
  );

`ifdef CORE_LSU_FAST_RESP_EN
  assign fast_hit = g_resetn && (state_q == LSU_REQ) && dmem_gnt && !dmem_err && !lsu_flush;
`else
  assign fast_hit = 1'b0;
`endif

  // Single FSM: latches the op at start, tracks the bus handshake and holds the result until the stage moves on.
  always_ff @(posedge g_clk) begin
    if (!g_resetn) begin
      state_q  <= LSU_IDLE;
      load_q   <= 1'b0;
      signed_q <= 1'b0;
      wen_q    <= 1'b0;
      rd_wen_q <= 1'b0;
      size_q   <= 2'd0;
      off_q    <= '0;
      cause_q  <= CAUSE_NONE;
      addr_q   <= '0;
      strb_q   <= '0;
      wdata_q  <= '0;
      rdata_q  <= '0;
    end else begin
      rd_wen_q <= 1'b0;
      case (state_q)
        LSU_IDLE: begin
          if (start) begin
            load_q   <= lsu_load;
            size_q   <= lsu_size;
            signed_q <= lsu_signed;
            off_q    <= off;
            if (misaligned) begin
              cause_q <= lsu_load ? CAUSE_LD_MISALIGN : CAUSE_ST_MISALIGN;
              state_q <= LSU_TRAP;
            end else begin
              cause_q <= CAUSE_NONE;
              addr_q  <= addr_d;
              wen_q   <= !lsu_load;
              strb_q  <= lsu_load ? '0 : fmt_strb;
              wdata_q <= fmt_wdata;
              state_q <= LSU_REQ;
            end
          end
        end
        LSU_REQ: begin
          if (dmem_gnt) begin
            if (lsu_flush) begin
              state_q <= LSU_IDLE;
            end else if (dmem_err) begin
              cause_q <= load_q ? CAUSE_LD_FAULT : CAUSE_ST_FAULT;
              state_q <= LSU_TRAP;
            end else begin
              if (load_q) rdata_q <= fmt_rdata;
              rd_wen_q <= load_q && !fast_hit;
              state_q  <= LSU_DONE;
            end
          end else if (lsu_flush) begin
            state_q <= LSU_DRAIN;
          end
        end
        LSU_DRAIN: begin
          if (dmem_gnt) state_q <= LSU_IDLE;
        end
        LSU_DONE, LSU_TRAP: begin
          if (lsu_new_instr || lsu_flush) state_q <= LSU_IDLE;
        end
        default: state_q <= LSU_IDLE;
      endcase
    end
  end

  assign lsu_ready      = (g_resetn && state_q == LSU_IDLE && !(lsu_valid && (lsu_load || lsu_store)))
                          || state_q == LSU_DONE || state_q == LSU_TRAP || fast_hit;
  assign lsu_rd_wen     = rd_wen_q || (fast_hit && load_q);
  assign lsu_rdata      = fast_hit ? fmt_rdata : rdata_q;
  assign lsu_trap       = (state_q == LSU_TRAP);
  assign lsu_trap_cause = lsu_trap ? cause_q : CAUSE_NONE;
  assign dmem_req       = (state_q == LSU_REQ) || (state_q == LSU_DRAIN);
  assign dmem_addr      = addr_q;
  assign dmem_wen       = wen_q;
  assign dmem_strb      = strb_q;
  assign dmem_wdata     = wdata_q;

endmodule

// File: tb/tb_core_pipe_exec_lsu.sv
// Self-checking bench for core_pipe_exec_lsu (default 64-bit build) with directed cases and a randomized op stream.
// Latency: n/a.
// Backpressure: the bench plays the dmem slave and stalls grants by a per-op delay.
module tb_core_pipe_exec_lsu;

`ifdef CORE_LSU_FAST_RESP_EN
  localparam bit FAST = 1'b1;
`else
  localparam bit FAST = 1'b0;
`endif

  logic        g_clk = 1'b0;
  logic        g_resetn;
  logic        lsu_valid, lsu_new_instr, lsu_flush, lsu_load, lsu_store, lsu_signed;
  logic [1:0]  lsu_size;
  logic [63:0] lsu_addr, lsu_wdata;
  logic        lsu_ready, lsu_rd_wen, lsu_trap;
  logic [63:0] lsu_rdata;
  logic [2:0]  lsu_trap_cause;
  logic        dmem_req, dmem_wen, dmem_gnt, dmem_err;
  logic [63:0] dmem_addr, dmem_wdata, dmem_rdata;
  logic [7:0]  dmem_strb;

  int checks = 0;
  int errors = 0;

  // Observations of the most recent op, filled by run_op.
  int          o_req_cyc, o_rdw, o_lat;
  bit          o_stable, o_timeout, o_ready0, o_idle_ready, o_idle_trap;
  logic        o_wen, o_trap;
  logic [2:0]  o_cause;
  logic [7:0]  o_strb;
  logic [63:0] o_addr, o_wdata, o_rdata, o_rdata2;

  core_pipe_exec_lsu #(.XLEN(64), .MEM_ADDR_W(64), .MEM_DATA_W(64)) dut (
    .g_clk(g_clk), .g_resetn(g_resetn),
    .lsu_valid(lsu_valid), .lsu_new_instr(lsu_new_instr), .lsu_flush(lsu_flush),
    .lsu_load(lsu_load), .lsu_store(lsu_store), .lsu_size(lsu_size), .lsu_signed(lsu_signed),
    .lsu_addr(lsu_addr), .lsu_wdata(lsu_wdata),
    .lsu_ready(lsu_ready), .lsu_rd_wen(lsu_rd_wen), .lsu_rdata(lsu_rdata),
    .lsu_trap(lsu_trap), .lsu_trap_cause(lsu_trap_cause),
    .dmem_req(dmem_req), .dmem_addr(dmem_addr), .dmem_wen(dmem_wen), .dmem_strb(dmem_strb),
    .dmem_wdata(dmem_wdata), .dmem_gnt(dmem_gnt), .dmem_err(dmem_err), .dmem_rdata(dmem_rdata)
  );

  always #5 g_clk = ~g_clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1);
  end

  // Reference: bus view of an op derived from byte-address arithmetic.
  function automatic void model(input bit ld, input logic [1:0] sz, input bit sg,
                                input logic [63:0] a, input logic [63:0] wd, input logic [63:0] rd,
                                output bit mis, output logic [63:0] ea, output logic [7:0] es,
                                output logic [63:0] ewd, output logic [63:0] erd);
    int nb, off;
    logic [63:0] v, m;
    nb  = 1 << sz;
    off = int'(a[2:0]);
    mis = (a % nb) != 0;
    ea  = a - 64'(off);
    es  = ld ? 8'd0 : 8'((((1 << nb) - 1) << off) & 255);
    ewd = wd << (8 * off);
    v   = rd >> (8 * off);
    if (nb < 8) begin
      m = (64'd1 << (8 * nb)) - 64'd1;
      v = v & m;
      if (sg && (((v >> (8 * nb - 1)) & 64'd1) != 0)) v = v | ~m;
    end
    erd = v;
  endfunction

  // Drives one op and plays the memory slave; gnt in REQ cycle gd (0 = first), optional flush in REQ cycle fl.
  task automatic run_op(input bit ld, input bit st, input logic [1:0] sz, input bit sg,
                        input logic [63:0] a, input logic [63:0] wd, input int gd, input bit er,
                        input logic [63:0] rd, input int fl);
    int c;
    bit done;
    o_req_cyc = 0; o_rdw = 0; o_lat = -1; o_stable = 1; o_timeout = 0; o_ready0 = 0;
    o_wen = 0; o_trap = 0; o_cause = 0; o_strb = 0; o_addr = 0; o_wdata = 0; o_rdata = 0;
    @(posedge g_clk); #1;
    lsu_valid = 1; lsu_load = ld; lsu_store = st; lsu_size = sz; lsu_signed = sg;
    lsu_addr = a; lsu_wdata = wd; lsu_new_instr = 0;
    c = 0; done = 0;
    while (!done && c < 60) begin
      dmem_gnt   = (c == 1 + gd);
      dmem_err   = er && (c == 1 + gd);
      dmem_rdata = (c == 1 + gd) ? rd : {$urandom, $urandom};
      lsu_flush  = (fl >= 0) && (c == 1 + fl);
      if (lsu_flush) lsu_valid = 0;
      @(negedge g_clk);
      if (c == 0) o_ready0 = lsu_ready;
      if (dmem_req) begin
        if (o_req_cyc == 0) begin
          o_addr = dmem_addr; o_wen = dmem_wen; o_strb = dmem_strb; o_wdata = dmem_wdata;
        end else if (dmem_addr !== o_addr || dmem_wen !== o_wen || dmem_strb !== o_strb || dmem_wdata !== o_wdata) begin
          o_stable = 0;
        end
        o_req_cyc++;
      end
      if (lsu_rd_wen) o_rdw++;
      if (c > 0 && lsu_ready) begin
        done = 1; o_lat = c; o_rdata = lsu_rdata; o_trap = lsu_trap; o_cause = lsu_trap_cause;
      end
      @(posedge g_clk); #1;
      c++;
    end
    if (!done) o_timeout = 1;
    dmem_gnt = 0; dmem_err = 0; lsu_flush = 0;
    @(negedge g_clk);
    if (lsu_rd_wen) o_rdw++;
    o_rdata2 = lsu_rdata;
    @(posedge g_clk); #1;
    lsu_new_instr = 1; lsu_valid = 0;
    @(posedge g_clk); #1;
    lsu_new_instr = 0;
    @(negedge g_clk);
    o_idle_ready = lsu_ready; o_idle_trap = lsu_trap;
  endtask

  task automatic test_reset();
    g_resetn = 0; lsu_valid = 0; lsu_new_instr = 0; lsu_flush = 0; lsu_load = 0; lsu_store = 0;
    lsu_size = 0; lsu_signed = 0; lsu_addr = 0; lsu_wdata = 0; dmem_gnt = 0; dmem_err = 0; dmem_rdata = 0;
    repeat (3) @(posedge g_clk);
    @(negedge g_clk);
    checks++; if ({dmem_req, lsu_ready, lsu_rd_wen, lsu_trap, dmem_wen} !== 5'b0) begin errors++; $display("FAIL reset_flags got=%b exp=00000", {dmem_req, lsu_ready, lsu_rd_wen, lsu_trap, dmem_wen}); end
    checks++; if (lsu_trap_cause !== 3'd0 || dmem_strb !== 8'd0) begin errors++; $display("FAIL reset_cause_strb got=%0d/%h exp=0/00", lsu_trap_cause, dmem_strb); end
    checks++; if (dmem_addr !== 64'd0 || dmem_wdata !== 64'd0 || lsu_rdata !== 64'd0) begin errors++; $display("FAIL reset_data got=%h/%h/%h exp=0", dmem_addr, dmem_wdata, lsu_rdata); end
    @(posedge g_clk); #1; g_resetn = 1;
    @(negedge g_clk);
    checks++; if (lsu_ready !== 1'b1 || dmem_req !== 1'b0) begin errors++; $display("FAIL idle_after_reset got ready=%b req=%b exp ready=1 req=0", lsu_ready, dmem_req); end
  endtask

  task automatic test_lb_signed();
    run_op(1, 0, 2'd0, 1, 64'h1003, 64'h0, 0, 0, 64'h00000000_80000000, -1);
    checks++; if (o_addr !== 64'h1000 || o_wen !== 1'b0 || o_strb !== 8'h00) begin errors++; $display("FAIL lb_bus got addr=%h wen=%b strb=%h exp 1000/0/00", o_addr, o_wen, o_strb); end
    checks++; if (o_rdata !== 64'hFFFFFFFF_FFFFFF80) begin errors++; $display("FAIL lb_rdata got=%h exp=ffffffffffffff80", o_rdata); end
    checks++; if (o_rdata2 !== 64'hFFFFFFFF_FFFFFF80) begin errors++; $display("FAIL lb_rdata_hold got=%h exp=ffffffffffffff80", o_rdata2); end
    checks++; if (o_rdw !== 1) begin errors++; $display("FAIL lb_rd_wen_count got=%0d exp=1", o_rdw); end
    checks++; if (o_lat !== (FAST ? 1 : 2) || o_ready0 !== 1'b0) begin errors++; $display("FAIL lb_latency got lat=%0d ready0=%b exp lat=%0d ready0=0", o_lat, o_ready0, FAST ? 1 : 2); end
  endtask

  task automatic test_sh();
    run_op(0, 1, 2'd1, 0, 64'h2006, 64'hBEEF, 0, 0, 64'h0, -1);
    checks++; if (o_addr !== 64'h2000 || o_strb !== 8'hC0 || o_wen !== 1'b1) begin errors++; $display("FAIL sh_bus got addr=%h strb=%h wen=%b exp 2000/c0/1", o_addr, o_strb, o_wen); end
    checks++; if (o_wdata !== 64'hBEEF0000_00000000) begin errors++; $display("FAIL sh_wdata got=%h exp=beef000000000000", o_wdata); end
    checks++; if (o_rdw !== 0 || o_trap !== 1'b0) begin errors++; $display("FAIL sh_no_wb got rdw=%0d trap=%b exp 0/0", o_rdw, o_trap); end
  endtask

  task automatic test_lw_misalign();
    run_op(1, 0, 2'd2, 0, 64'h3002, 64'h0, 0, 0, 64'h0, -1);
    checks++; if (o_req_cyc !== 0) begin errors++; $display("FAIL lw_mis_req got=%0d exp=0", o_req_cyc); end
    checks++; if (o_trap !== 1'b1 || o_cause !== 3'd1 || o_lat !== 1) begin errors++; $display("FAIL lw_mis_trap got trap=%b cause=%0d lat=%0d exp 1/1/1", o_trap, o_cause, o_lat); end
    checks++; if (o_idle_trap !== 1'b0 || o_idle_ready !== 1'b1) begin errors++; $display("FAIL lw_mis_clear got trap=%b ready=%b exp 0/1", o_idle_trap, o_idle_ready); end
  endtask

  task automatic test_ld_wait();
    run_op(1, 0, 2'd3, 0, 64'h5000, 64'h0, 3, 0, 64'h11223344_55667788, -1);
    checks++; if (o_req_cyc !== 4 || o_stable !== 1'b1) begin errors++; $display("FAIL ld_wait_hold got req_cycles=%0d stable=%b exp 4/1", o_req_cyc, o_stable); end
    checks++; if (o_lat !== (FAST ? 4 : 5)) begin errors++; $display("FAIL ld_wait_ready got lat=%0d exp=%0d", o_lat, FAST ? 4 : 5); end
    checks++; if (o_rdata !== 64'h11223344_55667788 || o_rdw !== 1) begin errors++; $display("FAIL ld_wait_data got=%h rdw=%0d exp=1122334455667788/1", o_rdata, o_rdw); end
  endtask

  task automatic test_sd_fault();
    run_op(0, 1, 2'd3, 0, 64'h4008, 64'hA5A5_0000_1234_5678, 1, 1, 64'h0, -1);
    checks++; if (o_trap !== 1'b1 || o_cause !== 3'd4 || o_lat !== 3) begin errors++; $display("FAIL sd_fault got trap=%b cause=%0d lat=%0d exp 1/4/3", o_trap, o_cause, o_lat); end
    checks++; if (o_rdw !== 0 || o_strb !== 8'hFF) begin errors++; $display("FAIL sd_fault_side got rdw=%0d strb=%h exp 0/ff", o_rdw, o_strb); end
  endtask

  task automatic test_flush_drain();
    logic [63:0] rd;
    run_op(1, 0, 2'd2, 0, 64'h6000, 64'h0, 2, 0, 64'hDEAD_BEEF, 0);
    checks++; if (o_req_cyc !== 3 || o_lat !== 4) begin errors++; $display("FAIL flush_drain got req_cycles=%0d ready_at=%0d exp 3/4", o_req_cyc, o_lat); end
    checks++; if (o_rdw !== 0 || o_trap !== 1'b0) begin errors++; $display("FAIL flush_side got rdw=%0d trap=%b exp 0/0", o_rdw, o_trap); end
    rd = {$urandom, $urandom};
    rd[7:0] = 8'hFF;
    run_op(1, 0, 2'd0, 0, 64'h10, 64'h0, 0, 0, rd, -1);
    checks++; if (o_rdata !== 64'hFF || o_rdw !== 1 || o_addr !== 64'h10) begin errors++; $display("FAIL lbu_after_flush got=%h rdw=%0d addr=%h exp ff/1/10", o_rdata, o_rdw, o_addr); end
  endtask

  task automatic test_reset_mid();
    @(posedge g_clk); #1;
    lsu_valid = 1; lsu_load = 1; lsu_store = 0; lsu_size = 2'd3; lsu_addr = 64'h7000;
    @(posedge g_clk); #1;
    @(negedge g_clk);
    checks++; if (dmem_req !== 1'b1) begin errors++; $display("FAIL mid_reset_req_before got=%b exp=1", dmem_req); end
    @(posedge g_clk); #1; g_resetn = 0; lsu_valid = 0;
    @(posedge g_clk);
    @(negedge g_clk);
    checks++; if (dmem_req !== 1'b0 || lsu_ready !== 1'b0) begin errors++; $display("FAIL mid_reset_drop got req=%b ready=%b exp 0/0", dmem_req, lsu_ready); end
    @(posedge g_clk); #1; g_resetn = 1;
  endtask

  task automatic test_random();
    bit ld, sg, er, mis;
    logic [1:0] sz;
    logic [63:0] a, wd, rd, ea, ewd, erd;
    logic [7:0] es;
    int gd, elat;
    for (int n = 0; n < 40; n++) begin
      ld = 1'($urandom_range(0, 1)); sg = 1'($urandom_range(0, 1)); er = ($urandom_range(0, 7) == 0);
      sz = 2'($urandom_range(0, 3)); gd = $urandom_range(0, 3);
      a = {32'h0, $urandom}; wd = {$urandom, $urandom}; rd = {$urandom, $urandom};
      if ($urandom_range(0, 3) != 0) a = a & ~64'((1 << sz) - 1);
      model(ld, sz, sg, a, wd, rd, mis, ea, es, ewd, erd);
      run_op(ld, !ld, sz, sg, a, wd, gd, er, rd, -1);
      checks++; if (o_timeout || o_idle_ready !== 1'b1 || o_ready0 !== 1'b0) begin errors++; $display("FAIL rnd%0d_handshake got timeout=%b idle_ready=%b ready0=%b exp 0/1/0", n, o_timeout, o_idle_ready, o_ready0); end
      if (mis) begin
        checks++; if (o_req_cyc !== 0 || o_trap !== 1'b1 || o_cause !== (ld ? 3'd1 : 3'd3) || o_lat !== 1) begin errors++; $display("FAIL rnd%0d_misalign got req=%0d trap=%b cause=%0d lat=%0d exp 0/1/%0d/1", n, o_req_cyc, o_trap, o_cause, o_lat, ld ? 1 : 3); end
      end else begin
        elat = (FAST && !er) ? gd + 1 : gd + 2;
        checks++; if (o_req_cyc !== gd + 1 || o_stable !== 1'b1 || o_lat !== elat) begin errors++; $display("FAIL rnd%0d_timing got req=%0d stable=%b lat=%0d exp %0d/1/%0d", n, o_req_cyc, o_stable, o_lat, gd + 1, elat); end
        checks++; if (o_addr !== ea || o_wen !== !ld || o_strb !== es) begin errors++; $display("FAIL rnd%0d_bus got addr=%h wen=%b strb=%h exp %h/%b/%h", n, o_addr, o_wen, o_strb, ea, !ld, es); end
        if (!ld) begin
          checks++; if (o_wdata !== ewd) begin errors++; $display("FAIL rnd%0d_wdata got=%h exp=%h", n, o_wdata, ewd); end
        end
        if (er) begin
          checks++; if (o_trap !== 1'b1 || o_cause !== (ld ? 3'd2 : 3'd4) || o_rdw !== 0) begin errors++; $display("FAIL rnd%0d_fault got trap=%b cause=%0d rdw=%0d exp 1/%0d/0", n, o_trap, o_cause, o_rdw, ld ? 2 : 4); end
        end else begin
          checks++; if (o_trap !== 1'b0 || o_rdw !== int'(ld)) begin errors++; $display("FAIL rnd%0d_wb got trap=%b rdw=%0d exp 0/%0d", n, o_trap, o_rdw, int'(ld)); end
          if (ld) begin
            checks++; if (o_rdata !== erd || o_rdata2 !== erd) begin errors++; $display("FAIL rnd%0d_rdata got=%h held=%h exp=%h", n, o_rdata, o_rdata2, erd); end
          end
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_lb_signed();
    test_sh();
    test_lw_misalign();
    test_ld_wait();
    test_sd_fault();
    test_flush_drain();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
